// File: rtl/con_ff_unit.sv
// CON flip-flop unit: decodes the IR branch condition, evaluates it against
// the bus or latched Z/N flags, and holds the result with valid and stats.
module con_ff_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int COND_LSB   = 19,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  con_in,
    input  logic [31:0]           ir_in,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic                  use_flags,
    input  logic                  flags_load,
    input  logic                  con_clr,
    output logic                  con_out,
    output logic                  con_valid,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic [CNT_WIDTH-1:0]  eval_count,
    output logic [CNT_WIDTH-1:0]  taken_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_capture;
    logic                 w_clr;
    logic [2:0]           r_cond;
    logic                 r_op_z;
    logic                 r_op_n;
    logic                 r_con;
    logic                 r_valid;
    logic                 r_flag_z;
    logic                 r_flag_n;
    logic [CNT_WIDTH-1:0] r_eval_cnt;
    logic [CNT_WIDTH-1:0] r_taken_cnt;
    logic                 w_bus_z;
    logic                 w_bus_n;
    logic                 w_op_z;
    logic                 w_op_n;
    logic                 w_result;
    logic [2:0]           w_cond;
    logic                 w_unused_ir;

    assign w_cond      = ir_in[COND_LSB+2:COND_LSB];
    assign w_unused_ir = ^ir_in;
    assign w_bus_z     = (bus_in == '0);
    assign w_bus_n     = bus_in[DATA_WIDTH-1];
    // Flag mode reads the registered flags, so a coincident load is not seen
    assign w_op_z      = use_flags ? r_flag_z : w_bus_z;
    assign w_op_n      = use_flags ? r_flag_n : w_bus_n;

    always_comb begin
        w_result = 1'b0;
        unique case (r_cond)
            3'b000: w_result = r_op_z;
            3'b001: w_result = !r_op_z;
            3'b010: w_result = !r_op_n;
            3'b011: w_result = r_op_n;
            3'b100: w_result = !r_op_n && !r_op_z;
            3'b101: w_result = r_op_n || r_op_z;
            3'b110: w_result = 1'b1;
            3'b111: w_result = 1'b0;
            default: w_result = 1'b0;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_clr     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (con_in) begin
                    w_capture = 1'b1;
                    w_next    = S_EVAL;
                end
            end
            S_EVAL: w_next = S_HOLD;
            S_HOLD: begin
                if (con_in) begin
                    w_capture = 1'b1;
                    w_next    = S_EVAL;
                end else if (con_clr) begin
                    w_clr  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_cond      <= '0;
            r_op_z      <= 1'b0;
            r_op_n      <= 1'b0;
            r_con       <= 1'b0;
            r_valid     <= 1'b0;
            r_flag_z    <= 1'b0;
            r_flag_n    <= 1'b0;
            r_eval_cnt  <= '0;
            r_taken_cnt <= '0;
        end else begin
            if (flags_load) begin
                r_flag_z <= w_bus_z;
                r_flag_n <= w_bus_n;
            end
            if (w_capture) begin
                r_cond  <= w_cond;
                r_op_z  <= w_op_z;
                r_op_n  <= w_op_n;
                r_valid <= 1'b0;
            end else if (w_clr) begin
                r_con   <= 1'b0;
                r_valid <= 1'b0;
            end else if (r_state == S_EVAL) begin
                r_con   <= w_result;
                r_valid <= 1'b1;
                if (r_eval_cnt != '1) begin
                    r_eval_cnt <= r_eval_cnt + 1'b1;
                end
                if (w_result && (r_taken_cnt != '1)) begin
                    r_taken_cnt <= r_taken_cnt + 1'b1;
                end
            end
        end
    end

    assign con_out     = r_con;
    assign con_valid   = r_valid;
    assign flag_z      = r_flag_z;
    assign flag_n      = r_flag_n;
    assign eval_count  = r_eval_cnt;
    assign taken_count = r_taken_cnt;

endmodule

// File: tb/tb_con_ff_unit.sv
// Directed bench for con_ff_unit with a result scoreboard and a 2-bit
// counter instance so saturation is reachable.
module tb_con_ff_unit;

    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          clear;
    logic          con_in;
    logic [31:0]   ir_in;
    logic [31:0]   bus_in;
    logic          use_flags;
    logic          flags_load;
    logic          con_clr;
    logic          con_out;
    logic          con_valid;
    logic          flag_z;
    logic          flag_n;
    logic [CW-1:0] eval_count;
    logic [CW-1:0] taken_count;

    typedef struct packed {
        logic       con;
        logic [1:0] ev;
        logic [1:0] tk;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_ev     = 0;
    int   m_tk     = 0;
    logic m_con    = 1'b0;
    logic mf_z     = 1'b0;
    logic mf_n     = 1'b0;

    con_ff_unit #(
        .DATA_WIDTH(32),
        .COND_LSB  (19),
        .CNT_WIDTH (CW)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .con_in     (con_in),
        .ir_in      (ir_in),
        .bus_in     (bus_in),
        .use_flags  (use_flags),
        .flags_load (flags_load),
        .con_clr    (con_clr),
        .con_out    (con_out),
        .con_valid  (con_valid),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .eval_count (eval_count),
        .taken_count(taken_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_fn(input logic [2:0] c, input logic z,
                                     input logic n);
        case (c)
            3'b000:  return z;
            3'b001:  return !z;
            3'b010:  return !n;
            3'b011:  return n;
            3'b100:  return !n && !z;
            3'b101:  return n || z;
            3'b110:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_ev  = 0;
        m_tk  = 0;
        m_con = 1'b0;
        mf_z  = 1'b0;
        mf_n  = 1'b0;
        sb.delete();
    endtask

    task automatic do_eval(input logic [2:0] code, input logic [31:0] bus,
                           input logic uf, input logic fl, input logic cc);
        logic z;
        logic n;
        exp_t e;
        z     = uf ? mf_z : (bus == 32'd0);
        n     = uf ? mf_n : bus[31];
        e.con = cond_fn(code, z, n);
        if (m_ev != 3) m_ev++;
        if (e.con && m_tk != 3) m_tk++;
        e.ev = 2'(m_ev);
        e.tk = 2'(m_tk);
        sb.push_back(e);
        if (fl) begin
            mf_z = (bus == 32'd0);
            mf_n = bus[31];
        end
        ir_in        = $urandom;
        ir_in[21:19] = code;
        bus_in       = bus;
        use_flags    = uf;
        flags_load   = fl;
        con_clr      = cc;
        con_in       = 1'b1;
        tick();
        con_in     = 1'b0;
        flags_load = 1'b0;
        bus_in     = $urandom;
        ir_in      = $urandom;
        use_flags  = 1'($urandom);
        chk("eval_valid_low", 32'(con_valid), 32'd0);
        chk("eval_con_kept", 32'(con_out), 32'(m_con));
        tick();
        con_clr = 1'b0;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("con_out", 32'(con_out), 32'(e.con));
            chk("con_valid", 32'(con_valid), 32'd1);
            chk("eval_count", 32'(eval_count), 32'(e.ev));
            chk("taken_count", 32'(taken_count), 32'(e.tk));
            m_con = e.con;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_con"}, 32'(con_out), 32'd0);
        chk({tag, "_valid"}, 32'(con_valid), 32'd0);
        chk({tag, "_fz"}, 32'(flag_z), 32'd0);
        chk({tag, "_fn"}, 32'(flag_n), 32'd0);
        chk({tag, "_ev"}, 32'(eval_count), 32'd0);
        chk({tag, "_tk"}, 32'(taken_count), 32'd0);
    endtask

    initial begin
        clear      = 1'b0;
        con_in     = 1'($urandom);
        ir_in      = $urandom;
        bus_in     = $urandom;
        use_flags  = 1'($urandom);
        flags_load = 1'($urandom);
        con_clr    = 1'($urandom);
        #1;
        chk_zero("rst_async");
        tick();
        tick();
        chk_zero("rst_held");
        con_in     = 1'b0;
        flags_load = 1'b0;
        con_clr    = 1'b0;
        use_flags  = 1'b0;
        clear      = 1'b1;
        model_reset();
        repeat (5) tick();
        chk_zero("rst_idle");

        do_eval(3'b000, 32'd0, 1'b0, 1'b0, 1'b0);
        do_eval(3'b000, 32'd5, 1'b0, 1'b0, 1'b0);

        do_eval(3'b011, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        do_eval(3'b100, 32'd0, 1'b0, 1'b0, 1'b0);
        do_eval(3'b101, 32'd0, 1'b0, 1'b0, 1'b0);
        do_eval(3'b110, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        do_eval(3'b111, 32'd0, 1'b0, 1'b0, 1'b0);
        do_eval(3'b100, 32'd7, 1'b0, 1'b0, 1'b0);
        do_eval(3'b010, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        do_eval(3'b001, 32'd1, 1'b0, 1'b0, 1'b0);

        flags_load = 1'b1;
        bus_in     = 32'd0;
        tick();
        flags_load = 1'b0;
        mf_z       = 1'b1;
        mf_n       = 1'b0;
        chk("flag_z_load", 32'(flag_z), 32'd1);
        do_eval(3'b000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        chk("flag_n_after", 32'(flag_n), 32'd1);
        chk("flag_z_after", 32'(flag_z), 32'd0);
        do_eval(3'b011, 32'd0, 1'b1, 1'b0, 1'b0);

        do_eval(3'b111, 32'd0, 1'b0, 1'b0, 1'b1);
        do_eval(3'b110, 32'd0, 1'b0, 1'b0, 1'b0);
        con_clr = 1'b1;
        tick();
        con_clr = 1'b0;
        m_con   = 1'b0;
        chk("clr_con", 32'(con_out), 32'd0);
        chk("clr_valid", 32'(con_valid), 32'd0);
        con_clr = 1'b1;
        tick();
        tick();
        con_clr = 1'b0;
        chk("idle_clr_valid", 32'(con_valid), 32'd0);
        chk("idle_clr_ev", 32'(eval_count), 32'(m_ev));
        do_eval(3'b110, 32'd0, 1'b0, 1'b0, 1'b0);

        clear = 1'b0;
        #1;
        model_reset();
        chk_zero("rst2");
        clear = 1'b1;
        tick();
        repeat (5) do_eval(3'b110, $urandom, 1'b0, 1'b0, 1'b0);
        chk("sat_ev", 32'(eval_count), 32'd3);
        chk("sat_tk", 32'(taken_count), 32'd3);

        ir_in        = 32'd0;
        ir_in[21:19] = 3'b110;
        con_in       = 1'b1;
        tick();
        con_in = 1'b0;
        clear  = 1'b0;
        #1;
        model_reset();
        chk_zero("rst_mid_eval");
        clear = 1'b1;
        tick();
        tick();
        chk_zero("post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/con_ff_unit.md
# con_ff_unit

Registered, parametrised branch-condition unit for the datapath control path. It decodes a 3-bit condition field from the instruction register and evaluates it against either the current bus value or a latched Z/N flag pair. The result is held in the CON flip-flop behind a small evaluate/hold state machine, with a valid flag and saturating statistics counters. The control unit consumes `con_out` to decide whether to load the branch target into PC.

## Interface
- `DATA_WIDTH`, 32, width of the evaluated bus operand.
- `COND_LSB`, 19, LSB of the 3-bit condition field in the IR (field is `ir_in[COND_LSB+2:COND_LSB]`).
- `CNT_WIDTH`, 16, width of each statistics counter.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `con_in`  in  1  evaluate strobe; starts one evaluation.
- `ir_in`  in  32  instruction register contents.
- `bus_in`  in  DATA_WIDTH  bus value to test.
- `use_flags`  in  1  sampled with `con_in`: 1 = test latched flags, 0 = test `bus_in`.
- `flags_load`  in  1  latch Z/N from `bus_in` this edge.
- `con_clr`  in  1  synchronous clear of CON and valid.
- `con_out`  out  1  CON flip-flop (branch taken).
- `con_valid`  out  1  `con_out` holds a completed evaluation.
- `flag_z`, `flag_n`  out  1 each  latched zero / negative flags.
- `eval_count`  out  CNT_WIDTH  evaluations completed, saturating.
- `taken_count`  out  CNT_WIDTH  evaluations with result 1, saturating.

## Operation
- Condition codes (c = field, Z = operand==0, N = operand MSB):
  - 000 Z
  - 001 !Z
  - 010 !N
  - 011 N
  - 100 !N & !Z
  - 101 N | Z
  - 110 always 1
  - 111 always 0
- Operand source:
  - `use_flags`=0: Z and N are computed from `bus_in`.
  - `use_flags`=1: Z and N are taken from `flag_z`/`flag_n` as registered before the current edge.
- Flags:
  - On `flags_load`: `flag_z` <= (`bus_in`==0), `flag_n` <= `bus_in[DATA_WIDTH-1]`.
  - If `flags_load` and `con_in` coincide with `use_flags`=1, the evaluation sees the old flags.
- FSM states IDLE, EVAL, HOLD:
  - IDLE, `con_in`=1: capture the condition code and the operand Z/N into internal registers. Clear `con_valid`. Go to EVAL.
  - EVAL: `con_out` <= result, `con_valid` <= 1, increment counters. Go to HOLD. `con_in` and `con_clr` are ignored in EVAL.
  - HOLD, `con_in`=1: recapture as from IDLE, drop `con_valid`. Go to EVAL. `con_out` keeps its old value until EVAL completes.
  - HOLD, `con_clr`=1 and `con_in`=0: `con_out` <= 0, `con_valid` <= 0. Go to IDLE.
  - HOLD, `con_in` and `con_clr` both 1: `con_in` wins (re-evaluate; no clear is performed).
  - IDLE, `con_clr`=1: no effect.
- Counters:
  - `eval_count` increments on every EVAL.
  - `taken_count` increments on EVAL when the result is 1.
  - Both saturate at 2^CNT_WIDTH-1 and never wrap.

## Timing
- Reset (`clear`=0, asynchronous):
  - State IDLE.
  - `con_out`=0, `con_valid`=0, `flag_z`=0, `flag_n`=0.
  - Both counters 0.
  - Reset asserted mid-EVAL aborts the evaluation; no counter increments.
- Latency: `con_in` sampled at edge k. `con_out`/`con_valid` update at edge k+1 (end of EVAL). Both are visible from after edge k+1 and remain stable through HOLD.
- Operand and condition are sampled only at edge k. `bus_in`/`ir_in` changes after edge k do not affect the result.
- Maximum throughput: one evaluation per 2 cycles (`con_in` held high re-triggers on every HOLD cycle).
- `con_valid` is low for exactly the one cycle spent in EVAL during any re-evaluation.

## Test plan
- Reset: drive `clear`=0 with random inputs -> all outputs 0. Release, idle 5 cycles -> outputs stay 0.
- Zero test: `ir_in[21:19]`=000, `bus_in`=0, pulse `con_in` at edge k -> `con_out`=1, `con_valid`=1 after edge k+1. Repeat with `bus_in`=5 -> `con_out`=0, `taken_count`=1, `eval_count`=2.
- Signed tests: code 011 with `bus_in`=0x80000000 -> 1. Code 100 with 0 -> 0. Code 101 with 0 -> 1. Code 110 -> 1. Code 111 -> 0.
- Flag mode hazard: `flags_load`=1 with `bus_in`=0 at edge k-1. Then at edge k, `flags_load`=1 with `bus_in`=0xFFFFFFFF, plus `con_in`=1, `use_flags`=1, code 000 -> `con_out`=1 (old Z used). Afterwards `flag_n`=1 and `flag_z`=0.
- Collision: in HOLD with `con_out`=1, assert `con_clr` and `con_in` together (code 111) -> `con_valid` low one cycle, then `con_out`=0, `con_valid`=1. `con_clr` alone from HOLD -> both 0 and FSM in IDLE.
- Saturation with `CNT_WIDTH`=2: 5 taken evaluations (code 110) -> both counters 3. Assert `clear` during an EVAL cycle -> counters 0, `con_valid`=0.
